// File: rtl/gameover_overlay_if.sv
// gameover_overlay_if: VGA stream bundle (timing, blanking and 12-bit colour) shared by video stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/gameover_overlay.sv
// gameover_overlay: realigns game stream with overlay and alpha-blends it with a frame-synchronous fade.
// Define GAMEOVER_FADE_EN for stepped fading; otherwise the overlay snaps between alpha 0 and 8.
module gameover_overlay #(
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vin,
    input  logic [11:0] ov_rgb,
    input  logic        ov_valid,
    input  logic        game_over,
    vga_if.out          vout,
    output logic        fade_busy,
    output logic [3:0]  alpha
);
    localparam logic [3:0] ALPHA_MAX = 4'd8;
    typedef enum logic [1:0] {HIDDEN, FADE_IN, SHOWN, FADE_OUT} state_t;
    state_t      state, state_n;
    logic [3:0]  alpha_n;
    logic [10:0] d1_hcount, d1_vcount;
    logic        d1_hsync, d1_vsync, d1_hblnk, d1_vblnk;
    logic [11:0] d1_rgb;
    logic        fs;
    assign fs = vin.hcount == '0 && vin.vcount == '0;
    function automatic logic [3:0] mix(input logic [3:0] bg, input logic [3:0] ov, input logic [3:0] a);
        logic [6:0] sum;
        sum = {3'd0, bg} * {3'd0, ALPHA_MAX - a} + {3'd0, ov} * {3'd0, a};
        return sum[6:3];
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_hcount <= '0;
            d1_vcount <= '0;
            d1_hsync  <= 1'b0;
            d1_vsync  <= 1'b0;
            d1_hblnk  <= 1'b0;
            d1_vblnk  <= 1'b0;
            d1_rgb    <= '0;
        end else begin
            d1_hcount <= vin.hcount;
            d1_vcount <= vin.vcount;
            d1_hsync  <= vin.hsync;
            d1_vsync  <= vin.vsync;
            d1_hblnk  <= vin.hblnk;
            d1_vblnk  <= vin.vblnk;
            d1_rgb    <= vin.rgb;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vout.hcount <= '0;
            vout.vcount <= '0;
            vout.hsync  <= 1'b0;
            vout.vsync  <= 1'b0;
            vout.hblnk  <= 1'b0;
            vout.vblnk  <= 1'b0;
            vout.rgb    <= '0;
        end else begin
            vout.hcount <= d1_hcount;
            vout.vcount <= d1_vcount;
            vout.hsync  <= d1_hsync;
            vout.vsync  <= d1_vsync;
            vout.hblnk  <= d1_hblnk;
            vout.vblnk  <= d1_vblnk;
            vout.rgb    <= (d1_hblnk || d1_vblnk) ? 12'h000 :
                           (ov_valid && alpha != 4'd0) ? {mix(d1_rgb[11:8], ov_rgb[11:8], alpha),
                                                          mix(d1_rgb[7:4], ov_rgb[7:4], alpha),
                                                          mix(d1_rgb[3:0], ov_rgb[3:0], alpha)} : d1_rgb;
        end
    end
`ifdef GAMEOVER_FADE_EN
    logic [7:0] fcnt, fcnt_n;
    logic       step, fading;
    assign step = fcnt == 8'(FRAMES_PER_STEP - 1);
    // a HIDDEN/SHOWN frame start that requests a change already counts as the first fade frame
    assign fading = state == FADE_IN || state == FADE_OUT ||
                    (state == HIDDEN && game_over) || (state == SHOWN && !game_over);
    always_comb begin
        state_n = state;
        alpha_n = alpha;
        fcnt_n  = fcnt;
        if (fs && fading) begin
            fcnt_n = step ? 8'd0 : fcnt + 8'd1;
            if (game_over) begin
                alpha_n = (step && alpha != ALPHA_MAX) ? alpha + 4'd1 : alpha;
                state_n = alpha_n == ALPHA_MAX ? SHOWN : FADE_IN;
            end else begin
                alpha_n = (step && alpha != 4'd0) ? alpha - 4'd1 : alpha;
                state_n = alpha_n == 4'd0 ? HIDDEN : FADE_OUT;
            end
        end
        if (state_n == HIDDEN || state_n == SHOWN)
            fcnt_n = '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fcnt <= '0;
        else
            fcnt <= fcnt_n;
    end
    assign fade_busy = state == FADE_IN || state == FADE_OUT;
`else
    always_comb begin
        state_n = state;
        alpha_n = alpha;
        if (fs && state == HIDDEN && game_over) begin
            state_n = SHOWN;
            alpha_n = ALPHA_MAX;
        end else if (fs && state == SHOWN && !game_over) begin
            state_n = HIDDEN;
            alpha_n = 4'd0;
        end
    end
    assign fade_busy = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HIDDEN;
            alpha <= 4'd0;
        end else begin
            state <= state_n;
            alpha <= alpha_n;
        end
    end
endmodule

// File: tb/tb_gameover_overlay.sv
// tb_gameover_overlay: directed vector bench for the overlay compositor (fade or snap build).
module tb_gameover_overlay;
    typedef struct {
        logic [11:0] bg;
        logic [11:0] ov;
        logic        valid;
        logic [1:0]  blnk;
        logic [11:0] exp;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        game_over = 1'b0;
    logic        ov_valid = 1'b0;
    logic [11:0] ov_rgb = '0;
    logic        fade_busy;
    logic [3:0]  alpha;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        t0[3];
    vec_t        t8[4];
    vec_t        mid;
    vga_if vin();
    vga_if vout();
    gameover_overlay #(.FRAMES_PER_STEP(2)) dut (
        .clk(clk),
        .rst(rst),
        .vin(vin),
        .ov_rgb(ov_rgb),
        .ov_valid(ov_valid),
        .game_over(game_over),
        .vout(vout),
        .fade_busy(fade_busy),
        .alpha(alpha)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic idle();
        vin.hcount = 11'd1;
        vin.vcount = 11'd1;
        vin.hsync  = 1'b0;
        vin.vsync  = 1'b0;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = '0;
    endtask
    task automatic frame();
        vin.hcount = 11'd0;
        vin.vcount = 11'd0;
        tick();
        vin.hcount = 11'd1;
        vin.vcount = 11'd1;
        tick();
        tick();
    endtask
    task automatic apply_vec(input vec_t v, input string name);
        vin.rgb   = v.bg;
        vin.hblnk = v.blnk[1];
        vin.vblnk = v.blnk[0];
        ov_valid  = 1'b0;
        tick();
        vin.rgb   = '0;
        vin.hblnk = 1'b0;
        vin.vblnk = 1'b0;
        ov_rgb    = v.ov;
        ov_valid  = v.valid;
        tick();
        ov_valid  = 1'b0;
        chk(name, vout.rgb, v.exp);
    endtask
    initial begin
        t0[0] = '{12'hABC, 12'h123, 1'b1, 2'b00, 12'hABC};
        t0[1] = '{12'h5A5, 12'hFFF, 1'b0, 2'b00, 12'h5A5};
        t0[2] = '{12'hFFF, 12'h000, 1'b1, 2'b10, 12'h000};
        t8[0] = '{12'hABC, 12'h123, 1'b1, 2'b00, 12'h123};
        t8[1] = '{12'hABC, 12'h123, 1'b0, 2'b00, 12'hABC};
        t8[2] = '{12'h777, 12'hF0F, 1'b1, 2'b10, 12'h000};
        t8[3] = '{12'h777, 12'hF0F, 1'b1, 2'b01, 12'h000};
        mid   = '{12'hF00, 12'h00F, 1'b1, 2'b00, 12'h707};
        idle();
        tick();
        tick();
        chk("reset_alpha", alpha, 0);
        chk("reset_busy", fade_busy, 0);
        chk("reset_rgb", vout.rgb, 0);
        chk("reset_hcount", vout.hcount, 0);
        rst = 1'b0;
        tick();
        vin.hsync = 1'b1;
        vin.vsync = 1'b1;
        tick();
        vin.hsync = 1'b0;
        vin.vsync = 1'b0;
        chk("hsync_lag1", vout.hsync, 0);
        tick();
        chk("hsync_lag2", vout.hsync, 1);
        chk("vsync_lag2", vout.vsync, 1);
        tick();
        chk("hsync_lag3", vout.hsync, 0);
        for (int i = 0; i < 3; i++)
            apply_vec(t0[i], $sformatf("pass_%0d", i));
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        tick();
        frame();
        chk("glitch_alpha", alpha, 0);
        chk("glitch_busy", fade_busy, 0);
`ifdef GAMEOVER_FADE_EN
        game_over = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            frame();
            chk($sformatf("fadein_alpha_f%0d", i), alpha, i / 2);
            chk($sformatf("fadein_busy_f%0d", i), fade_busy, i < 16 ? 1 : 0);
            if (i == 8)
                apply_vec(mid, "blend_a4");
        end
        for (int i = 0; i < 4; i++)
            apply_vec(t8[i], $sformatf("full_%0d", i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 6; i++)
            frame();
        chk("rev_start_alpha", alpha, 3);
        game_over = 1'b0;
        for (int j = 7; j <= 12; j++) begin
            frame();
            chk($sformatf("fadeout_alpha_f%0d", j), alpha, 3 - (j - 6) / 2);
            chk($sformatf("fadeout_busy_f%0d", j), fade_busy, j < 12 ? 1 : 0);
        end
        game_over = 1'b1;
        for (int i = 1; i <= 10; i++)
            frame();
        chk("pre_rst_alpha", alpha, 5);
`else
        game_over = 1'b1;
        tick();
        chk("snap_wait_alpha", alpha, 0);
        frame();
        chk("snap_on_alpha", alpha, 8);
        chk("snap_on_busy", fade_busy, 0);
        for (int i = 0; i < 4; i++)
            apply_vec(t8[i], $sformatf("full_%0d", i));
        game_over = 1'b0;
        frame();
        chk("snap_off_alpha", alpha, 0);
        apply_vec(t0[0], "snap_off_pass");
        game_over = 1'b1;
        frame();
        chk("pre_rst_alpha", alpha, 8);
`endif
        vin.rgb  = 12'h0F0;
        ov_rgb   = 12'hF0F;
        ov_valid = 1'b1;
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_alpha", alpha, 0);
        chk("async_rst_busy", fade_busy, 0);
        chk("async_rst_rgb", vout.rgb, 0);
        chk("async_rst_hcount", vout.hcount, 0);
        tick();
        chk("rst_hold_rgb", vout.rgb, 0);
        rst = 1'b0;
        ov_valid = 1'b0;
        idle();
        frame();
`ifdef GAMEOVER_FADE_EN
        chk("restart_alpha", alpha, 0);
        chk("restart_busy", fade_busy, 1);
`else
        chk("restart_alpha", alpha, 8);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gameover_overlay.md
# gameover_overlay

Compositing stage directly downstream of the game-over box renderer. Takes the main game VGA stream and the renderer's registered `rgb`/`valid` pair, realigns them, and alpha-blends the overlay onto the scene with a frame-synchronous fade-in/fade-out controlled by a game-over level signal. Output is a full `vga_if` stream feeding the next stage toward the VGA pins.

## Interface
Parameters:
- `FRAMES_PER_STEP`, default 4: frames between alpha steps; legal 1..255.
- `ALPHA_MAX`, fixed 8: full-opacity alpha level; not user-overridable.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `vin`  `vga_if.in`  -  game stream: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb[11:0].
- `ov_rgb`  in  12  overlay colour from renderer, one cycle behind `vin`.
- `ov_valid`  in  1  overlay pixel present, one cycle behind `vin`.
- `game_over`  in  1  level; 1 = overlay requested.
- `vout`  `vga_if.out`  -  composited stream.
- `fade_busy`  out  1  high in FADE_IN or FADE_OUT.
- `alpha`  out  4  current alpha, 0..8.

## Operation
- Stage 1 registers all `vin` fields (d1) so they align with `ov_rgb`/`ov_valid`.
- Stage 2 registers timing fields from d1 into `vout` and computes `vout.rgb`.
- Blend per 4-bit channel c: if `ov_valid` && alpha>0 then out = (bg_c*(8-alpha) + ov_c*alpha) >> 3, else out = bg_c. Products ≤120; sum held in 7 bits; truncate, no rounding. alpha=8 yields exactly ov_c.
- If d1 hblnk or vblnk is set, `vout.rgb` = 12'h000 regardless of overlay.
- Frame start `fs` = (vin.hcount==0 && vin.vcount==0), one cycle pulse.
- Frame counter `fcnt` (8 bit) increments on `fs`; on reaching FRAMES_PER_STEP-1 it wraps to 0 and issues `step`. `fcnt` clears to 0 whenever state is HIDDEN or SHOWN.
- State machine (state and alpha change only on `fs` cycles):
  - HIDDEN (alpha 0): `game_over`=1 at `fs` -> FADE_IN.
  - FADE_IN: on `step` alpha+1; alpha reaching 8 -> SHOWN. `game_over`=0 at any `fs` -> FADE_OUT, alpha kept.
  - SHOWN (alpha 8): `game_over`=0 at `fs` -> FADE_OUT.
  - FADE_OUT: on `step` alpha-1; reaching 0 -> HIDDEN. `game_over`=1 at `fs` -> FADE_IN, alpha kept.
- `game_over` toggling between frame starts is ignored; only the value sampled at `fs` counts.
- Alpha never exceeds 8 nor underflows below 0.

## Timing
- Reset values: all `vout` fields 0, `alpha` 0, `fade_busy` 0, state HIDDEN, `fcnt` 0, d1 registers 0.
- `vout` timing fields lag `vin` by exactly 2 cycles; `vout.rgb` lags `ov_rgb` by 1 cycle.
- Alpha update takes effect on the cycle after `fs`, i.e. uniformly for the whole frame's visible pixels.
- From `game_over` rising before a `fs`: alpha reaches 1 after FRAMES_PER_STEP frame starts, 8 after 8*FRAMES_PER_STEP.
- Reset asserted mid-fade: immediate return to reset values; no partial frame output retained.

## Configuration
- `GAMEOVER_FADE_EN` defined: fade behaviour as above.
- Not defined: no frame counter; at `fs`, HIDDEN with `game_over`=1 jumps to SHOWN (alpha 8), SHOWN with `game_over`=0 jumps to HIDDEN (alpha 0); `fade_busy` tied 0; blend still used (alpha only 0 or 8).

## Test plan
- Reset mid-frame with `game_over`=1, alpha 5 -> all outputs 0, state HIDDEN, `vout.rgb`=0 next cycle.
- Pass-through: `game_over`=0, vin.rgb=12'hABC, `ov_valid`=1 -> `vout.rgb`=12'hABC two cycles later; hsync/vsync delayed exactly 2.
- Full fade-in, FRAMES_PER_STEP=2: raise `game_over` -> alpha steps 1..8 every 2 frames, SHOWN after 16 frame starts; bg 12'hF00, ov 12'h00F at alpha 4 -> `vout.rgb`=12'h707.
- Reversal: drop `game_over` at alpha 3 during FADE_IN -> FADE_OUT, alpha 2,1,0, then HIDDEN, `fade_busy`=0.
- Blanking: hblnk=1 with `ov_valid`=1, alpha 8 -> `vout.rgb`=12'h000.
- Macro off: raise `game_over` -> alpha 0->8 at next `fs`, `vout.rgb`=ov_rgb inside box; drop -> alpha 0 at next `fs`.
